servo_pwm: RTL and testbench
============================

Name: servo_pwm

Overview:
- Downstream consumer of the 10-bit RC channel value produced by the radio PWM receiver; regenerates a standard servo/ESC PWM output from it.
- Runs on the same 1 MHz clock; one count = 1 us.
- Treats the incoming value as asynchronous, filters it, and applies it only at frame boundaries. The output pulse is therefore never torn mid-frame.

Parameters:
- PERIOD, 16'd20000: frame length in clocks (20 ms); must exceed OFFSET+1023.
- OFFSET, 11'd988: pulse width in us for val = 0; val = 1023 gives 2011 us.
- DEFAULT, 10'd512: command value loaded at reset (1500 us pulse).
- MAX_STEP, 10'd32: maximum per-frame width change; used only when SERVO_SLEW_EN is defined.

Ports:
- clk_1M  input  1  1 MHz system clock; all logic on posedge.
- rst  input  1  synchronous, active-low reset (0 = reset, sampled on posedge clk_1M).
- en  input  1  output enable; 1 = generate frames, 0 = stop after the current frame.
- val  input  10  channel command from the radio receiver; asynchronous to clk_1M.
- pwm  output  1  servo PWM output.
- frame  output  1  one-cycle strobe on the first cycle of every frame.
- width  output  11  pulse width (us) applied to the current frame.

Behaviour:
- Reset (rst = 0 at posedge), all registered:
  - state = IDLE, ctr = 0, pwm = 0, frame = 0.
  - width = OFFSET + DEFAULT (1500).
  - Sync stages s1 and s2 = DEFAULT; cmd = DEFAULT.
  - Reset asserted mid-frame aborts the frame immediately; pwm is 0 the next cycle.
- Input capture:
  - Every cycle: s1 <= val, s2 <= s1.
  - cmd <= s2 only when s1 == s2. This rejects multi-bit skew while the radio's val register changes.
  - cmd is never used combinationally on pwm.
- Width arithmetic:
  - target = OFFSET + cmd, computed zero-extended to 11 bits.
  - Maximum is 988 + 1023 = 2011, so no overflow.
- State machine:
  - IDLE: ctr held at 0, pwm = 0. If en = 1, go to RUN at the next edge and start a frame.
  - RUN, frame start (ctr loaded to 0):
    - frame = 1 for that cycle only.
    - width <= target (or the slewed value, see Optional Feature).
    - pwm = 1.
  - RUN, each subsequent cycle: ctr increments. pwm = 1 while ctr < width, else 0.
  - pwm is high for exactly width cycles per frame. Frame length is exactly PERIOD cycles (ctr 0..PERIOD-1).
  - At ctr == PERIOD-1:
    - If en = 1: ctr wraps to 0 and a new frame starts (back-to-back, no gap).
    - If en = 0: go to IDLE; pwm stays 0.
- en deassert mid-frame: the current frame completes unchanged, including the pulse.
- en reasserted before frame end: no effect; frames continue seamlessly.
- Latency:
  - en sampled high in IDLE: frame and pwm rise at the next posedge (1 cycle).
  - val change to applied width: 3 cycles minimum through capture, then waits for the next frame start.
- A val change within the same cycle as the frame start is not seen until the following frame.
- width changes only on frame-start cycles.

Optional Feature:
- Macro SERVO_SLEW_EN.
- When defined, at each frame start:
  - If |target - width| <= MAX_STEP: width <= target.
  - Otherwise width moves toward target by exactly MAX_STEP.
  - Arithmetic is 11-bit unsigned and is never allowed to cross target.
  - Reset value is still OFFSET + DEFAULT.
- When not defined: width <= target directly at each frame start, and MAX_STEP is unused.

Test Plan:
- Reset with rst = 0 for 5 cycles, then rst = 1, en = 1 -> frame pulses 1 cycle after en is sampled; pwm high 1500 cycles, low 18500; width = 1500.
- val = 0 then val = 1023 across successive frames -> width 988, pwm high 988 cycles; then width 2011, pwm high 2011 cycles; period stays 20000.
- val changes from 100 to 900 at ctr = 500 mid-pulse -> current frame keeps its old width to the end; next frame uses 1888.
- val toggles for 1 cycle (skew glitch, s1 != s2) -> cmd unchanged, width unchanged.
- en dropped at ctr = 10000 -> frame completes to ctr 19999, then IDLE with pwm = 0; en raised again -> new frame 1 cycle later. Separately, rst = 0 at ctr = 700 -> pwm = 0 the next cycle, width = 1500.
- With SERVO_SLEW_EN, start at 1500 and set val = 1023 -> width steps 1532, 1564, ... then clamps at 2011 without overshoot. Without the macro -> 2011 in the first frame.

Source files
------------

// File: rtl/servo_pwm_if.sv
// ============================================================================
//  Module      : servo_pwm_if
//  Description : Command/status bundle between a servo PWM regenerator and
//                its user.  The master supplies the enable and the raw RC
//                channel value; the slave returns the PWM line, the
//                frame-start strobe and the pulse width applied to the frame.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

interface servo_pwm_if;
  logic        en;     // 1 = generate frames, 0 = stop after current frame
  logic [9:0]  val;    // channel command, asynchronous to the servo clock
  logic        pwm;    // servo PWM output
  logic        frame;  // one-cycle strobe on the first cycle of each frame
  logic [10:0] width;  // pulse width (us) applied to the current frame

  modport master (
    output en,
    output val,
    input  pwm,
    input  frame,
    input  width
  );

  modport slave (
    input  en,
    input  val,
    output pwm,
    output frame,
    output width
  );
endinterface

`default_nettype wire

// File: rtl/servo_pwm.sv
// ============================================================================
//  Module      : servo_pwm
//  Description : Regenerates a standard servo/ESC PWM signal from a 10-bit
//                RC channel value.  One clock = 1 us.  The incoming value is
//                double-registered, accepted only when both stages agree,
//                and applied to the output only at frame boundaries, so a
//                pulse is never torn mid-frame.
//                Optional build macro SERVO_SLEW_EN limits the change of the
//                pulse width per frame to MAX_STEP (the MAX_STEP parameter
//                exists only in that build).
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module servo_pwm #(
  parameter logic [15:0] PERIOD   = 16'd20000, // frame length in clocks
  parameter logic [10:0] OFFSET   = 11'd988,   // pulse width for val = 0
  parameter logic [9:0]  DEFAULT  = 10'd512    // command loaded at reset
`ifdef SERVO_SLEW_EN
  ,
  parameter logic [9:0]  MAX_STEP = 10'd32     // largest width change per frame
`endif
) (
  input  wire logic  clk_1M,
  input  wire logic  rst,      // synchronous, active low
  servo_pwm_if.slave bus
);

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  localparam logic [15:0] c_LAST_CTR    = PERIOD - 16'd1;
  localparam logic [10:0] c_RESET_WIDTH = OFFSET + {1'b0, DEFAULT};

  state_t      r_state;
  logic [15:0] r_ctr;
  logic        r_pwm;
  logic        r_frame;
  logic [10:0] r_width;

  logic [9:0]  r_s1;
  logic [9:0]  r_s2;
  logic [9:0]  r_cmd;

  logic [10:0] w_target;
  logic [10:0] w_next_width;
  logic [15:0] w_ctr_inc;

  // Capture the asynchronous command: two sync stages, and the command is
  // only updated when both stages agree, which rejects multi-bit skew while
  // the source register is changing.
  always_ff @(posedge clk_1M) begin
    if (!rst) begin
      r_s1  <= DEFAULT;
      r_s2  <= DEFAULT;
      r_cmd <= DEFAULT;
    end else begin
      r_s1 <= bus.val;
      r_s2 <= r_s1;
      if (r_s1 == r_s2) begin
        r_cmd <= r_s2;
      end
    end
  end

  // Requested pulse width; 988 + 1023 = 2011 always fits in 11 bits.
  assign w_target = OFFSET + {1'b0, r_cmd};

`ifdef SERVO_SLEW_EN
  localparam logic [10:0] c_STEP = {1'b0, MAX_STEP};

  logic [10:0] w_up_gap;
  logic [10:0] w_dn_gap;

  // Move toward the target by at most one step; the gap is compared before
  // stepping so the width can never overshoot the target.
  always_comb begin
    w_up_gap     = w_target - r_width;
    w_dn_gap     = r_width - w_target;
    w_next_width = w_target;
    if (w_target > r_width) begin
      if (w_up_gap > c_STEP) begin
        w_next_width = r_width + c_STEP;
      end
    end else if (w_dn_gap > c_STEP) begin
      w_next_width = r_width - c_STEP;
    end
  end
`else
  assign w_next_width = w_target;
`endif

  assign w_ctr_inc = r_ctr + 16'd1;

  // Frame sequencer: all outputs registered; the width is latched only on
  // frame-start cycles and pwm is high while the frame counter is below it.
  always_ff @(posedge clk_1M) begin
    if (!rst) begin
      r_state <= IDLE;
      r_ctr   <= '0;
      r_pwm   <= 1'b0;
      r_frame <= 1'b0;
      r_width <= c_RESET_WIDTH;
    end else begin
      r_frame <= 1'b0;
      case (r_state)
        IDLE: begin
          r_ctr <= '0;
          r_pwm <= 1'b0;
          if (bus.en) begin
            r_state <= RUN;
            r_frame <= 1'b1;
            r_width <= w_next_width;
            r_pwm   <= (w_next_width != 11'd0);
          end
        end
        RUN: begin
          if (r_ctr == c_LAST_CTR) begin
            r_ctr <= '0;
            if (bus.en) begin
              // back-to-back frame, no gap cycle
              r_frame <= 1'b1;
              r_width <= w_next_width;
              r_pwm   <= (w_next_width != 11'd0);
            end else begin
              r_state <= IDLE;
              r_pwm   <= 1'b0;
            end
          end else begin
            r_ctr <= w_ctr_inc;
            r_pwm <= (w_ctr_inc < {5'd0, r_width});
          end
        end
        default: begin
          r_state <= IDLE;
          r_ctr   <= '0;
          r_pwm   <= 1'b0;
        end
      endcase
    end
  end

  assign bus.pwm   = r_pwm;
  assign bus.frame = r_frame;
  assign bus.width = r_width;

endmodule

`default_nettype wire

// File: tb/tb_servo_pwm.sv
// ============================================================================
//  Module      : tb_servo_pwm
//  Description : Self-checking bench for servo_pwm.  A short frame period is
//                used so many frames fit in the run; expected widths come
//                from a frame-level model of the command/slew rules.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_servo_pwm;

  localparam int P   = 2048;
  localparam int OFF = 988;
  localparam int DEF = 512;
`ifdef SERVO_SLEW_EN
  localparam int STEP = 32;
`endif

  logic clk_1M = 1'b0;
  logic rst    = 1'b0;

  servo_pwm_if bus();

  servo_pwm #(
    .PERIOD  (16'd2048),
    .OFFSET  (11'd988),
    .DEFAULT (10'd512)
  ) dut (
    .clk_1M (clk_1M),
    .rst    (rst),
    .bus    (bus)
  );

  always #500 clk_1M = ~clk_1M;

  int checks   = 0;
  int failures = 0;

  // Frame-level model: command seen by the next frame and the width applied.
  int m_cmd;
  int m_width;

  function automatic int model_step();
    int t;
    t = OFF + m_cmd;
`ifdef SERVO_SLEW_EN
    if (t - m_width > STEP)       m_width = m_width + STEP;
    else if (m_width - t > STEP)  m_width = m_width - STEP;
    else                          m_width = t;
`else
    m_width = t;
`endif
    return m_width;
  endfunction

  // Observe one full frame starting at a frame-start sample; optional
  // mid-frame action (1 = new val, 2 = drop en, 3 = one-cycle val glitch,
  // 4 = drop en then raise it 300 cycles later).  Ends on the first sample
  // of the following cycle after the frame.
  task automatic measure_frame(input int act_at, input int act, input logic [9:0] act_val,
                               output int hi, output logic [10:0] w, output int odd);
    logic [9:0] saved;
    logic       prev;
    hi    = 0;
    odd   = 0;
    w     = bus.width;
    saved = bus.val;
    prev  = 1'b1;
    for (int i = 0; i < P; i++) begin
      if (bus.pwm === 1'b1) hi++;
      if (bus.pwm === 1'b1 && prev === 1'b0) odd++;
      prev = bus.pwm;
      if (i > 0 && bus.frame !== 1'b0) odd++;
      if (bus.width !== w) odd++;
      if (i == act_at) begin
        case (act)
          1: bus.val = act_val;
          2: bus.en  = 1'b0;
          3: bus.val = act_val;
          4: bus.en  = 1'b0;
          default: ;
        endcase
      end
      if (act == 3 && i == act_at + 1) bus.val = saved;
      if (act == 4 && i == act_at + 300) bus.en = 1'b1;
      @(negedge clk_1M);
    end
  endtask

  task automatic test_reset();
    int hi, odd, exp;
    logic [10:0] w;
    rst = 1'b0; bus.en = 1'b0; bus.val = 10'd512;
    repeat (5) @(negedge clk_1M);
    checks++; if (bus.pwm !== 1'b0) begin failures++; $display("FAIL reset_pwm: got %b expected 0", bus.pwm); end
    checks++; if (bus.frame !== 1'b0) begin failures++; $display("FAIL reset_frame: got %b expected 0", bus.frame); end
    checks++; if (bus.width !== 11'd1500) begin failures++; $display("FAIL reset_width: got %0d expected 1500", bus.width); end
    m_cmd = DEF; m_width = OFF + DEF;
    rst = 1'b1; bus.en = 1'b1;
    @(negedge clk_1M);
    checks++; if (bus.frame !== 1'b1 || bus.pwm !== 1'b1) begin failures++; $display("FAIL reset_start_latency: frame=%b pwm=%b expected 1 1", bus.frame, bus.pwm); end
    exp = model_step();
    measure_frame(-1, 0, 10'd0, hi, w, odd);
    checks++; if ({21'd0, w} !== exp) begin failures++; $display("FAIL reset_frame_width: got %0d expected %0d", w, exp); end
    checks++; if (hi !== exp) begin failures++; $display("FAIL reset_pulse_len: got %0d expected %0d", hi, exp); end
    checks++; if (odd !== 0) begin failures++; $display("FAIL reset_frame_shape: got %0d anomalies expected 0", odd); end
    checks++; if (bus.frame !== 1'b1) begin failures++; $display("FAIL reset_period: frame=%b expected 1 after %0d cycles", bus.frame, P); end
  endtask

  task automatic test_extremes();
    int hi, odd, exp;
    logic [10:0] w;
    logic [9:0]  v;
    for (int k = 0; k < 3; k++) begin
      exp = model_step();
      v = (k == 0) ? 10'd0 : 10'd1023;
      bus.val = v;
      measure_frame(-1, 0, 10'd0, hi, w, odd);
      m_cmd = int'(v);
      checks++; if ({21'd0, w} !== exp) begin failures++; $display("FAIL extremes_width f%0d: got %0d expected %0d", k, w, exp); end
      checks++; if (hi !== exp) begin failures++; $display("FAIL extremes_pulse f%0d: got %0d expected %0d", k, hi, exp); end
      checks++; if (odd !== 0) begin failures++; $display("FAIL extremes_shape f%0d: got %0d expected 0", k, odd); end
      checks++; if (bus.frame !== 1'b1) begin failures++; $display("FAIL extremes_period f%0d: frame=%b expected 1", k, bus.frame); end
    end
  endtask

  task automatic test_random();
    int hi, odd, exp;
    logic [10:0] w;
    logic [9:0]  v;
    for (int k = 0; k < 4; k++) begin
      exp = model_step();
      v = 10'($urandom_range(0, 1023));
      bus.val = v;
      measure_frame(-1, 0, 10'd0, hi, w, odd);
      m_cmd = int'(v);
      checks++; if ({21'd0, w} !== exp) begin failures++; $display("FAIL random_width f%0d: got %0d expected %0d", k, w, exp); end
      checks++; if (hi !== exp) begin failures++; $display("FAIL random_pulse f%0d: got %0d expected %0d", k, hi, exp); end
      checks++; if (odd !== 0 || bus.frame !== 1'b1) begin failures++; $display("FAIL random_shape f%0d: anomalies=%0d frame=%b expected 0 1", k, odd, bus.frame); end
    end
  endtask

  task automatic test_mid_change();
    int hi, odd, exp;
    logic [10:0] w;
    for (int k = 0; k < 3; k++) begin
      exp = model_step();
      if (k == 0) begin
        bus.val = 10'd100;
        measure_frame(-1, 0, 10'd0, hi, w, odd);
        m_cmd = 100;
      end else if (k == 1) begin
        measure_frame(500, 1, 10'd900, hi, w, odd);
        m_cmd = 900;
      end else begin
        measure_frame(-1, 0, 10'd0, hi, w, odd);
      end
      checks++; if ({21'd0, w} !== exp) begin failures++; $display("FAIL midchange_width f%0d: got %0d expected %0d", k, w, exp); end
      checks++; if (hi !== exp) begin failures++; $display("FAIL midchange_pulse f%0d: got %0d expected %0d", k, hi, exp); end
      checks++; if (odd !== 0 || bus.frame !== 1'b1) begin failures++; $display("FAIL midchange_shape f%0d: anomalies=%0d frame=%b expected 0 1", k, odd, bus.frame); end
    end
  endtask

  task automatic test_glitch();
    int hi, odd, exp;
    logic [10:0] w;
    for (int k = 0; k < 3; k++) begin
      exp = model_step();
      if (k < 2) measure_frame(P - 4 + k, 3, bus.val ^ 10'h2AA, hi, w, odd);
      else       measure_frame(-1, 0, 10'd0, hi, w, odd);
      checks++; if ({21'd0, w} !== exp) begin failures++; $display("FAIL glitch_width f%0d: got %0d expected %0d", k, w, exp); end
      checks++; if (hi !== exp || odd !== 0 || bus.frame !== 1'b1) begin failures++; $display("FAIL glitch_frame f%0d: pulse=%0d anomalies=%0d expected %0d 0", k, hi, odd, exp); end
    end
  endtask

  task automatic test_en_drop();
    int hi, odd, exp, busy;
    logic [10:0] w;
    exp = model_step();
    measure_frame(1000, 2, 10'd0, hi, w, odd);
    checks++; if (hi !== exp || {21'd0, w} !== exp) begin failures++; $display("FAIL endrop_complete: pulse=%0d width=%0d expected %0d", hi, w, exp); end
    checks++; if (odd !== 0) begin failures++; $display("FAIL endrop_shape: got %0d anomalies expected 0", odd); end
    busy = 0;
    for (int i = 0; i < 40; i++) begin
      if (bus.pwm !== 1'b0 || bus.frame !== 1'b0) busy++;
      @(negedge clk_1M);
    end
    checks++; if (busy !== 0) begin failures++; $display("FAIL endrop_idle: got %0d active cycles expected 0", busy); end
    bus.en = 1'b1;
    @(negedge clk_1M);
    checks++; if (bus.frame !== 1'b1 || bus.pwm !== 1'b1) begin failures++; $display("FAIL endrop_restart: frame=%b pwm=%b expected 1 1", bus.frame, bus.pwm); end
  endtask

  task automatic test_en_blip();
    int hi, odd, exp;
    logic [10:0] w;
    exp = model_step();
    measure_frame(500, 4, 10'd0, hi, w, odd);
    checks++; if (hi !== exp || {21'd0, w} !== exp || odd !== 0) begin failures++; $display("FAIL enblip_frame: pulse=%0d width=%0d anomalies=%0d expected %0d", hi, w, odd, exp); end
    checks++; if (bus.frame !== 1'b1) begin failures++; $display("FAIL enblip_seamless: frame=%b expected 1", bus.frame); end
  endtask

  task automatic test_reset_mid();
    int exp;
    exp = model_step();
    repeat (700) @(negedge clk_1M);
    checks++; if (bus.pwm !== (exp > 700 ? 1'b1 : 1'b0)) begin failures++; $display("FAIL rstmid_before: pwm=%b expected %b", bus.pwm, exp > 700); end
    rst = 1'b0; bus.val = 10'd512;
    @(negedge clk_1M);
    checks++; if (bus.pwm !== 1'b0 || bus.frame !== 1'b0) begin failures++; $display("FAIL rstmid_abort: pwm=%b frame=%b expected 0 0", bus.pwm, bus.frame); end
    checks++; if (bus.width !== 11'd1500) begin failures++; $display("FAIL rstmid_width: got %0d expected 1500", bus.width); end
    repeat (2) @(negedge clk_1M);
    m_cmd = DEF; m_width = OFF + DEF;
    rst = 1'b1;
    @(negedge clk_1M);
    checks++; if (bus.frame !== 1'b1 || bus.width !== 11'd1500) begin failures++; $display("FAIL rstmid_restart: frame=%b width=%0d expected 1 1500", bus.frame, bus.width); end
  endtask

  task automatic test_slew();
    int hi, odd, exp, n, need;
    logic [10:0] w;
    exp = model_step();
    bus.val = 10'd1023;
    measure_frame(-1, 0, 10'd0, hi, w, odd);
    m_cmd = 1023;
    checks++; if ({21'd0, w} !== exp || hi !== exp) begin failures++; $display("FAIL slew_start: width=%0d pulse=%0d expected %0d", w, hi, exp); end
    n = 0;
    for (int k = 0; k < 20; k++) begin
      exp = model_step();
      measure_frame(-1, 0, 10'd0, hi, w, odd);
      n++;
      checks++; if ({21'd0, w} !== exp) begin failures++; $display("FAIL slew_width f%0d: got %0d expected %0d", k, w, exp); end
      checks++; if (hi !== exp || odd !== 0 || bus.frame !== 1'b1) begin failures++; $display("FAIL slew_frame f%0d: pulse=%0d anomalies=%0d expected %0d 0", k, hi, odd, exp); end
      if (exp == 2011) break;
    end
`ifdef SERVO_SLEW_EN
    need = (2011 - 1500 + STEP - 1) / STEP;
`else
    need = 1;
`endif
    checks++; if (n !== need) begin failures++; $display("FAIL slew_frames_to_target: got %0d expected %0d", n, need); end
  endtask

  initial begin
    #(64'd200000 * 64'd1000);
    $display("FAIL watchdog: run did not end within 200000 cycles");
    $fatal(1, "watchdog expired");
  end

  initial begin
    bus.en  = 1'b0;
    bus.val = 10'd512;
    test_reset();
    test_extremes();
    test_random();
    test_mid_change();
    test_glitch();
    test_en_drop();
    test_en_blip();
    test_reset_mid();
    test_slew();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
